// File: rtl/systolic_feed_controller.sv
// Sequencer for the 2x2 systolic convolution array (3x3 filter over a 4x4 tile).
// Collects 16 pixels and 9 taps, clears the array, drives the four skewed edge
// feeds for 14 cycles, waits out the array pipeline and holds the four results
// behind a valid/ready handshake.
module systolic_feed_controller #(
  parameter int DATA_W    = 8,
  parameter int DRAIN_CYC = 3
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  input  logic              abort,
  output logic              busy,
  input  logic              load_valid,
  output logic              load_ready,
  input  logic [DATA_W-1:0] load_data,
  output logic [DATA_W-1:0] row_a,
  output logic [DATA_W-1:0] row_b,
  output logic [DATA_W-1:0] col_a,
  output logic [DATA_W-1:0] col_b,
  output logic              arr_clr,
  output logic              feed_valid,
  input  logic [DATA_W-1:0] c11_in,
  input  logic [DATA_W-1:0] c12_in,
  input  logic [DATA_W-1:0] c21_in,
  input  logic [DATA_W-1:0] c22_in,
  output logic              res_valid,
  input  logic              res_ready,
  output logic [DATA_W-1:0] res11,
  output logic [DATA_W-1:0] res12,
  output logic [DATA_W-1:0] res21,
  output logic [DATA_W-1:0] res22,
  output logic              done
);

  // Beats 0..15 are the tile (row-major), beats 16..24 the taps (row-major).
  localparam int NBEATS = 25;
  localparam logic [4:0] LAST_BEAT = 5'(NBEATS - 1);
  localparam logic [4:0] LAST_FEED = 5'd13;
  localparam logic [4:0] LAST_DRAIN = 5'(DRAIN_CYC - 1);

  typedef enum logic [2:0] {
    S_IDLE,
    S_LOAD,
    S_CLEAR,
    S_FEED,
    S_DRAIN,
    S_HOLD
  } state_t;

  state_t            state_q, state_d;
  logic [4:0]        cnt_q, cnt_d;
  logic [DATA_W-1:0] buf_q [NBEATS];
  logic [DATA_W-1:0] buf_d [NBEATS];
  logic [DATA_W-1:0] row_a_q, row_a_d, row_b_q, row_b_d;
  logic [DATA_W-1:0] col_a_q, col_a_d, col_b_q, col_b_d;
  logic [DATA_W-1:0] res11_q, res11_d, res12_q, res12_d;
  logic [DATA_W-1:0] res21_q, res21_d, res22_q, res22_d;
  logic              busy_q, busy_d, load_ready_q, load_ready_d;
  logic              arr_clr_q, arr_clr_d, feed_valid_q, feed_valid_d;
  logic              res_valid_q, res_valid_d, done_q, done_d;

  logic              feed_ld;
  logic [3:0]        nk;
  logic [5:0]        sel_a, sel_b;

  // Column-feed tap selector for feed index k: {hit, buffer index}.
  // Taps go out in reverse order (f33 first), three per group of four cycles,
  // the fourth cycle of each group being a zero bubble.
  function automatic logic [5:0] col_sel(input logic [3:0] k);
    if (k < 4'd11 && k[1:0] != 2'd3)
      col_sel = {1'b1, 5'd24 - 5'd3 * {3'b000, k[3:2]} - {3'b000, k[1:0]}};
    else
      col_sel = '0;
  endfunction

  // Next-state, buffer writes, feed schedule and result capture.
  always_comb begin
    state_d      = state_q;
    cnt_d        = cnt_q;
    buf_d        = buf_q;
    row_a_d      = '0;
    row_b_d      = '0;
    col_a_d      = '0;
    col_b_d      = '0;
    arr_clr_d    = 1'b0;
    feed_valid_d = 1'b0;
    res_valid_d  = 1'b0;
    done_d       = 1'b0;
    res11_d      = res11_q;
    res12_d      = res12_q;
    res21_d      = res21_q;
    res22_d      = res22_q;
    feed_ld      = 1'b0;
    nk           = '0;
    sel_a        = '0;
    sel_b        = '0;

    if (abort && state_q != S_IDLE) begin
      // Abort wins over everything; buffers and last results are kept.
      state_d = S_IDLE;
      cnt_d   = '0;
    end else begin
      case (state_q)
        S_IDLE: begin
          if (start) begin
            state_d = S_LOAD;
            cnt_d   = '0;
          end
        end
        S_LOAD: begin
          if (load_valid && load_ready_q) begin
            buf_d[cnt_q] = load_data;
            if (cnt_q == LAST_BEAT) begin
              state_d   = S_CLEAR;
              cnt_d     = '0;
              arr_clr_d = 1'b1;
            end else begin
              cnt_d = cnt_q + 5'd1;
            end
          end
        end
        S_CLEAR: begin
          state_d      = S_FEED;
          cnt_d        = '0;
          feed_ld      = 1'b1;
          nk           = 4'd0;
          feed_valid_d = 1'b1;
        end
        S_FEED: begin
          if (cnt_q == LAST_FEED) begin
            state_d = S_DRAIN;
            cnt_d   = '0;
          end else begin
            cnt_d        = cnt_q + 5'd1;
            feed_ld      = 1'b1;
            nk           = cnt_q[3:0] + 4'd1;
            feed_valid_d = 1'b1;
          end
        end
        S_DRAIN: begin
          if (cnt_q == LAST_DRAIN) begin
            state_d     = S_HOLD;
            cnt_d       = '0;
            res11_d     = c11_in;
            res12_d     = c12_in;
            res21_d     = c21_in;
            res22_d     = c22_in;
            res_valid_d = 1'b1;
            done_d      = 1'b1;
          end else begin
            cnt_d = cnt_q + 5'd1;
          end
        end
        S_HOLD: begin
          if (res_ready) begin
            state_d = S_IDLE;
          end else begin
            res_valid_d = 1'b1;
          end
        end
        default: begin
          state_d = S_IDLE;
          cnt_d   = '0;
        end
      endcase
    end

    // Feeds are registered: load the values for the upcoming feed index nk.
    if (feed_ld) begin
      if (nk < 4'd12)
        row_a_d = buf_q[{1'b0, nk}];
      if (nk >= 4'd1 && nk <= 4'd12)
        row_b_d = buf_q[{1'b0, nk} + 5'd3];
      sel_a = col_sel(nk);
      if (sel_a[5])
        col_a_d = buf_q[sel_a[4:0]];
      sel_b = col_sel(nk - 4'd2);
      if (nk >= 4'd2 && sel_b[5])
        col_b_d = buf_q[sel_b[4:0]];
    end

    busy_d       = (state_d != S_IDLE);
    load_ready_d = (state_d == S_LOAD);
  end

  // State, counters, buffers and registered outputs.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q      <= S_IDLE;
      cnt_q        <= '0;
      for (int i = 0; i < NBEATS; i++) buf_q[i] <= '0;
      row_a_q      <= '0;
      row_b_q      <= '0;
      col_a_q      <= '0;
      col_b_q      <= '0;
      res11_q      <= '0;
      res12_q      <= '0;
      res21_q      <= '0;
      res22_q      <= '0;
      busy_q       <= 1'b0;
      load_ready_q <= 1'b0;
      arr_clr_q    <= 1'b0;
      feed_valid_q <= 1'b0;
      res_valid_q  <= 1'b0;
      done_q       <= 1'b0;
    end else begin
      state_q      <= state_d;
      cnt_q        <= cnt_d;
      buf_q        <= buf_d;
      row_a_q      <= row_a_d;
      row_b_q      <= row_b_d;
      col_a_q      <= col_a_d;
      col_b_q      <= col_b_d;
      res11_q      <= res11_d;
      res12_q      <= res12_d;
      res21_q      <= res21_d;
      res22_q      <= res22_d;
      busy_q       <= busy_d;
      load_ready_q <= load_ready_d;
      arr_clr_q    <= arr_clr_d;
      feed_valid_q <= feed_valid_d;
      res_valid_q  <= res_valid_d;
      done_q       <= done_d;
    end
  end

  assign busy       = busy_q;
  assign load_ready = load_ready_q;
  assign row_a      = row_a_q;
  assign row_b      = row_b_q;
  assign col_a      = col_a_q;
  assign col_b      = col_b_q;
  assign arr_clr    = arr_clr_q;
  assign feed_valid = feed_valid_q;
  assign res_valid  = res_valid_q;
  assign res11      = res11_q;
  assign res12      = res12_q;
  assign res21      = res21_q;
  assign res22      = res22_q;
  assign done       = done_q;

endmodule

// File: tb/tb_systolic_feed_controller.sv
// Bench for systolic_feed_controller: a behavioural 2x2 systolic array closes
// the loop on the feeds, and expected feeds/results come from the schedule
// tables and a direct 3x3 convolution of the loaded tile.
module tb_systolic_feed_controller;

  localparam int DW = 8;
  localparam int DC = 3;

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic          start = 1'b0;
  logic          abort = 1'b0;
  logic          load_valid = 1'b0;
  logic          res_ready = 1'b0;
  logic [DW-1:0] load_data = '0;
  logic          busy, load_ready, arr_clr, feed_valid, res_valid, done;
  logic [DW-1:0] row_a, row_b, col_a, col_b;
  logic [DW-1:0] c11_in, c12_in, c21_in, c22_in;
  logic [DW-1:0] res11, res12, res21, res22;

  int total = 0;
  int bad   = 0;

  // Tile and taps of the current job, row-major.
  logic [DW-1:0] px_m [16];
  logic [DW-1:0] tp_m [9];
  // Results the DUT should currently be holding.
  logic [DW-1:0] prev11 = '0, prev12 = '0, prev21 = '0, prev22 = '0;

  // Feed schedules as element indices (-1 = literal zero).
  int ra_ix [14] = '{0, 1, 2, 3, 4, 5, 6, 7, 8, 9, 10, 11, -1, -1};
  int rb_ix [14] = '{-1, 4, 5, 6, 7, 8, 9, 10, 11, 12, 13, 14, 15, -1};
  int ca_ix [14] = '{8, 7, 6, -1, 5, 4, 3, -1, 2, 1, 0, -1, -1, -1};
  int cb_ix [14] = '{-1, -1, 8, 7, 6, -1, 5, 4, 3, -1, 2, 1, 0, -1};

  systolic_feed_controller #(.DATA_W(DW), .DRAIN_CYC(DC)) dut (
    .clk(clk), .rst(rst), .start(start), .abort(abort), .busy(busy),
    .load_valid(load_valid), .load_ready(load_ready), .load_data(load_data),
    .row_a(row_a), .row_b(row_b), .col_a(col_a), .col_b(col_b),
    .arr_clr(arr_clr), .feed_valid(feed_valid),
    .c11_in(c11_in), .c12_in(c12_in), .c21_in(c21_in), .c22_in(c22_in),
    .res_valid(res_valid), .res_ready(res_ready),
    .res11(res11), .res12(res12), .res21(res21), .res22(res22),
    .done(done)
  );

  always #5 clk = ~clk;

  // Behavioural 2x2 output-stationary array: operands pass right/down with one cycle delay.
  logic [DW-1:0] acc11, acc12, acc21, acc22, a11p, b11p, a21p, b12p;
  always @(posedge clk or negedge rst) begin
    if (!rst || arr_clr) begin
      acc11 <= '0; acc12 <= '0; acc21 <= '0; acc22 <= '0;
      a11p <= '0; b11p <= '0; a21p <= '0; b12p <= '0;
    end else begin
      acc11 <= acc11 + row_a * col_a;
      acc12 <= acc12 + a11p * col_b;
      acc21 <= acc21 + row_b * b11p;
      acc22 <= acc22 + a21p * b12p;
      a11p  <= row_a;
      b11p  <= col_a;
      a21p  <= row_b;
      b12p  <= col_b;
    end
  end
  assign c11_in = acc11;
  assign c12_in = acc12;
  assign c21_in = acc21;
  assign c22_in = acc22;

  initial begin
    #200000;
    $display("FAIL watchdog timeout total=%0d bad=%0d", total, bad);
    $fatal(1, "watchdog");
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  function automatic logic [DW-1:0] pv(input int ix);
    if (ix < 0) return '0;
    return px_m[ix];
  endfunction

  function automatic logic [DW-1:0] tv(input int ix);
    if (ix < 0) return '0;
    return tp_m[ix];
  endfunction

  // True 3x3 convolution (filter flipped) giving output (r,c), truncated to DW bits.
  function automatic logic [DW-1:0] conv(input int r, input int c);
    int s;
    s = 0;
    for (int i = 0; i < 3; i++)
      for (int j = 0; j < 3; j++)
        s += px_m[(r + i) * 4 + (c + j)] * tp_m[(2 - i) * 3 + (2 - j)];
    return s[DW-1:0];
  endfunction

  task automatic check_all_zero(input string tag);
    chk({tag, " busy"}, busy, 0);
    chk({tag, " load_ready"}, load_ready, 0);
    chk({tag, " arr_clr"}, arr_clr, 0);
    chk({tag, " feed_valid"}, feed_valid, 0);
    chk({tag, " res_valid"}, res_valid, 0);
    chk({tag, " done"}, done, 0);
    chk({tag, " feeds"}, {row_a, row_b, col_a, col_b}, 0);
    chk({tag, " res"}, {res11, res12, res21, res22}, 0);
  endtask

  // mode 0: load_valid always 1; 1: toggling 1,0,1,0; 2: random.
  task automatic do_load(input int mode);
    int i, guard;
    logic lv, rdy;
    start = 1'b1;
    tick();
    start = 1'b0;
    chk("load_ready_up", load_ready, 1);
    chk("busy_load", busy, 1);
    i = 0;
    guard = 0;
    while (i < 25 && guard < 300) begin
      lv = (mode == 0) ? 1'b1 : (mode == 1) ? (guard % 2 == 0) : 1'($urandom_range(0, 1));
      load_valid = lv;
      load_data  = (i < 16) ? px_m[i] : tp_m[i - 16];
      rdy = load_ready;
      tick();
      if (lv && rdy) i++;
      guard++;
    end
    load_valid = 1'b0;
    chk("load_beats", i, 25);
  endtask

  task automatic check_clear();
    chk("clear arr_clr", arr_clr, 1);
    chk("clear load_ready", load_ready, 0);
    chk("clear feed_valid", feed_valid, 0);
    chk("clear feeds", {row_a, row_b, col_a, col_b}, 0);
  endtask

  task automatic feed_steps(input int n);
    for (int k = 0; k < n; k++) begin
      tick();
      chk($sformatf("feed_valid k%0d", k), feed_valid, 1);
      chk($sformatf("arr_clr k%0d", k), arr_clr, 0);
      chk($sformatf("row_a k%0d", k), row_a, pv(ra_ix[k]));
      chk($sformatf("row_b k%0d", k), row_b, pv(rb_ix[k]));
      chk($sformatf("col_a k%0d", k), col_a, tv(ca_ix[k]));
      chk($sformatf("col_b k%0d", k), col_b, tv(cb_ix[k]));
    end
  endtask

  task automatic drain_and_capture();
    for (int d = 0; d < DC; d++) begin
      tick();
      chk($sformatf("drain feeds d%0d", d), {row_a, row_b, col_a, col_b}, 0);
      chk($sformatf("drain feed_valid d%0d", d), feed_valid, 0);
      chk($sformatf("drain done d%0d", d), done, 0);
      chk($sformatf("drain busy d%0d", d), busy, 1);
    end
    tick();
    chk("capture done", done, 1);
    chk("capture res_valid", res_valid, 1);
    chk("res11", res11, conv(0, 0));
    chk("res12", res12, conv(0, 1));
    chk("res21", res21, conv(1, 0));
    chk("res22", res22, conv(1, 1));
    prev11 = conv(0, 0);
    prev12 = conv(0, 1);
    prev21 = conv(1, 0);
    prev22 = conv(1, 1);
  endtask

  task automatic hold_phase(input int n);
    for (int i = 0; i < n; i++) begin
      res_ready = 1'b0;
      tick();
      chk($sformatf("hold res_valid c%0d", i), res_valid, 1);
      chk($sformatf("hold done c%0d", i), done, 0);
      chk($sformatf("hold res c%0d", i), {res11, res12, res21, res22},
          {prev11, prev12, prev21, prev22});
    end
    res_ready = 1'b1;
    tick();
    res_ready = 1'b0;
    chk("xfer res_valid", res_valid, 0);
    chk("xfer busy", busy, 0);
    chk("xfer done", done, 0);
    chk("xfer res kept", {res11, res12, res21, res22}, {prev11, prev12, prev21, prev22});
  endtask

  task automatic run_full(input int mode, input int hold_n);
    do_load(mode);
    check_clear();
    feed_steps(14);
    drain_and_capture();
    hold_phase(hold_n);
  endtask

  initial begin
    // Reset state.
    #2 rst = 1'b0;
    tick();
    tick();
    check_all_zero("reset");
    rst = 1'b1;
    tick();
    check_all_zero("post_reset");

    // load_data = beat index, load_valid always 1, res_ready in first HOLD cycle.
    for (int i = 0; i < 16; i++) px_m[i] = DW'(i);
    for (int i = 0; i < 9; i++) tp_m[i] = DW'(16 + i);
    run_full(0, 0);

    // All ones -> every output 9.
    for (int i = 0; i < 16; i++) px_m[i] = 8'd1;
    for (int i = 0; i < 9; i++) tp_m[i] = 8'd1;
    run_full(0, 2);
    chk("ones res", {res11, res12, res21, res22}, {8'd9, 8'd9, 8'd9, 8'd9});

    // Pixels 1..16, only f22 = 1; load_valid toggling.
    for (int i = 0; i < 16; i++) px_m[i] = DW'(i + 1);
    for (int i = 0; i < 9; i++) tp_m[i] = (i == 4) ? 8'd1 : 8'd0;
    run_full(1, 1);
    chk("f22 res", {res11, res12, res21, res22}, {8'd6, 8'd7, 8'd10, 8'd11});

    // Random tiles, taps and load stalls.
    for (int r = 0; r < 3; r++) begin
      for (int i = 0; i < 16; i++) px_m[i] = DW'($urandom);
      for (int i = 0; i < 9; i++) tp_m[i] = DW'($urandom);
      run_full(2, int'($urandom_range(0, 3)));
    end

    // Asynchronous reset in the middle of FEED (k = 6).
    for (int i = 0; i < 16; i++) px_m[i] = DW'($urandom);
    for (int i = 0; i < 9; i++) tp_m[i] = DW'($urandom);
    do_load(2);
    check_clear();
    feed_steps(7);
    #2 rst = 1'b0;
    #1 check_all_zero("rst_mid_feed");
    prev11 = '0; prev12 = '0; prev21 = '0; prev22 = '0;
    #3 rst = 1'b1;
    tick();
    chk("after_rst busy", busy, 0);
    chk("after_rst load_ready", load_ready, 0);

    // Abort in DRAIN together with start.
    for (int i = 0; i < 16; i++) px_m[i] = DW'($urandom);
    for (int i = 0; i < 9; i++) tp_m[i] = DW'($urandom);
    do_load(0);
    check_clear();
    feed_steps(14);
    tick();
    chk("drain0 done", done, 0);
    abort = 1'b1;
    start = 1'b1;
    tick();
    abort = 1'b0;
    start = 1'b0;
    chk("abort busy", busy, 0);
    chk("abort load_ready", load_ready, 0);
    chk("abort res_valid", res_valid, 0);
    chk("abort done", done, 0);
    chk("abort feed_valid", feed_valid, 0);
    for (int i = 0; i < 6; i++) begin
      tick();
      chk($sformatf("post_abort done c%0d", i), done, 0);
      chk($sformatf("post_abort res_valid c%0d", i), res_valid, 0);
      chk($sformatf("post_abort busy c%0d", i), busy, 0);
    end
    chk("post_abort res kept", {res11, res12, res21, res22}, {prev11, prev12, prev21, prev22});

    // Second start after abort runs normally; consumer stalls 5 cycles.
    run_full(0, 5);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/systolic_feed_controller.md
Name: systolic_feed_controller

Overview:
Sequencer for the 2x2 systolic convolution array, which computes a 3x3 filter over a 4x4 input tile to give a 2x2 output.
- Accepts a start request and streams in 16 input pixels plus 9 filter taps over a valid/ready load port.
- Clears the array accumulators, then drives the four skewed edge feeds (row_a, row_b, col_a, col_b) for 14 cycles.
- Waits out the pipeline, captures c11..c22 and holds them behind a valid/ready result handshake.

Parameters:
DATA_W, 8, width of pixels, taps, feeds and results
DRAIN_CYC, 3, zero-feed cycles after the last feed before results are captured (array pipeline depth)

Ports:
clk  in  1  clock, all state on rising edge
rst  in  1  asynchronous, active-low reset (asserted when 0)
start  in  1  request a new convolution; accepted only in IDLE
abort  in  1  synchronous abort; returns to IDLE from any state
busy  out  1  high in every state except IDLE
load_valid  in  1  load beat valid
load_ready  out  1  high only in LOAD
load_data  in  DATA_W  pixel/tap value
row_a, row_b  out  DATA_W  row feeds to the array
col_a, col_b  out  DATA_W  column feeds to the array
arr_clr  out  1  one-cycle accumulator clear to the array
feed_valid  out  1  high during the 14 FEED cycles
c11_in, c12_in, c21_in, c22_in  in  DATA_W  array results
res_valid  out  1  results held and valid
res_ready  in  1  consumer accepts results
res11, res12, res21, res22  out  DATA_W  captured results
done  out  1  one-cycle pulse on capture

Behaviour:
- Reset (rst=0, asynchronous):
  - State goes to IDLE and all counters to 0.
  - Buffers and all outputs go to 0: busy, load_ready, arr_clr, feed_valid, res_valid, done, feeds, res*.
- States: IDLE -> LOAD -> CLEAR -> FEED -> DRAIN -> HOLD -> IDLE.
- IDLE:
  - start=1 moves to LOAD on the next edge; beat counter is set to 0.
  - start in any other state is ignored.
- LOAD:
  - load_ready=1; each cycle with load_valid&load_ready writes buf[cnt] and increments cnt.
  - Beats 0..15 are the input tile, row-major: in11, in12, in13, in14, in21, ... in44.
  - Beats 16..24 are the taps, row-major: f11 .. f33.
  - The edge accepting beat 24 moves to CLEAR.
  - load_valid=0 stalls with no write.
- CLEAR: exactly one cycle with arr_clr=1 and feeds 0, then FEED with k=0.
- FEED, k=0..13, one cycle each:
  - Feeds are registered outputs, so during the cycle with index k they hold schedule[k] below.
  - feed_valid=1.
  - After k=13, move to DRAIN.
  - row_a: in11, in12, in13, in14, in21, in22, in23, in24, in31, in32, in33, in34, 0, 0
  - row_b: 0, in21, in22, in23, in24, in31, in32, in33, in34, in41, in42, in43, in44, 0
  - col_a: f33, f32, f31, 0, f23, f22, f21, 0, f13, f12, f11, 0, 0, 0
  - col_b: 0, 0, f33, f32, f31, 0, f23, f22, f21, 0, f13, f12, f11, 0
- DRAIN:
  - Feeds are 0 for DRAIN_CYC cycles.
  - On the edge ending the last DRAIN cycle, c**_in are latched into res**, state goes to HOLD, and done pulses for exactly 1 cycle.
- HOLD:
  - res_valid=1 and res** are stable.
  - res_valid&res_ready moves to IDLE and deasserts res_valid.
  - res_ready=1 in the first HOLD cycle is legal.
  - res** keep their values after the transfer until the next capture.
- abort=1 in any non-IDLE state:
  - Next state is IDLE; feeds, arr_clr, feed_valid and res_valid go to 0.
  - Buffers and res** are unchanged.
  - abort in IDLE has no effect.
  - abort has priority over start, load beats and res_ready in the same cycle.
- Latency: from the cycle after beat 24 is accepted to done = 1 (CLEAR) + 14 + DRAIN_CYC = 18 cycles at defaults.
- Arithmetic: the controller performs no math; it only carries DATA_W values. Zero entries are literal 0.

Test Plan:
- Reset mid-FEED (rst=0 at k=6) -> all outputs 0 asynchronously; after release, state is IDLE and load_ready=0.
- start, 25 beats with load_data=beat index (0..24) and load_valid always 1 -> arr_clr 1 cycle, then row_a=0,1,2,3,4,5,6,7,8,9,10,11,0,0 and col_b=0,0,24,23,22,0,21,20,19,0,18,17,16,0 on consecutive cycles; done exactly 18 cycles after the last beat.
- With golden array model: all pixels=1, all taps=1 -> res11=res12=res21=res22=9, res_valid=1 until res_ready.
- With golden array model: pixels 1..16, only f22=1 -> res11=6, res12=7, res21=10, res22=11.
- load_valid toggling 1,0,1,0 -> exactly 25 writes, no skipped or duplicated beats.
- abort during DRAIN with start=1 the same cycle -> IDLE next cycle, no done and no res_valid. A second start then accepted behaves normally; res_ready held low for 5 cycles keeps res_valid and res** stable.
